// File: rtl/af_scheduler.sv
// rtl/af_scheduler.sv - round-robin burst scheduler feeding a shared activation-function cluster
//
// Purpose: NUM_REQ psum producers share one activation-function cluster.
// An IDLE/BURST state machine grants one requester at a time for BURST_LEN
// words. The granted word goes through a one-deep registered output stage.
// The scheduler also owns the cluster mode register, which can change only
// while the datapath is drained.
//
// Ports:
//   clk_i, rst_ni                - clock, asynchronous active-low reset
//   req_data_i                   - packed requester words, requester k at [k*DATA_BITWIDTH +: DATA_BITWIDTH]
//   req_enable_i / req_ready_o   - per-requester valid / ready
//   data_o / enable_o / ready_i  - registered output word, its valid, downstream ready
//   grant_o                      - current or last burst owner
//   busy_o                       - high while a burst is in progress
//   mode_cfg_i / mode_we_i       - mode write value / strobe
//   mode_ack_o                   - one-cycle pulse when a mode write is accepted
//   mode_o                       - mode to the cluster

module af_scheduler #(
    parameter int DATA_BITWIDTH = 40,
    parameter int MODES         = 2,
    parameter int NUM_REQ       = 4,
    parameter int BURST_LEN     = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_REQ*DATA_BITWIDTH-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]                 req_enable_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic [DATA_BITWIDTH-1:0]           data_o,
    output logic                               enable_o,
    input  logic                               ready_i,
    output logic [$clog2(NUM_REQ)-1:0]         grant_o,
    output logic                               busy_o,
    input  logic [$clog2(MODES)-1:0]           mode_cfg_i,
    input  logic                               mode_we_i,
    output logic                               mode_ack_o,
    output logic [$clog2(MODES)-1:0]           mode_o
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int MW = $clog2(MODES);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [GW-1:0]            grant_q, grant_d;
    logic [GW-1:0]            ptr_q, ptr_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [DATA_BITWIDTH-1:0] data_q, data_d;
    logic                     en_q, en_d;
    logic [MW-1:0]            mode_q, mode_d;
    logic                     ack_q, ack_d;

    logic                     out_free;
    logic                     xfer;
    logic                     mode_ok;
    logic [GW:0]              pick;
    logic [DATA_BITWIDTH-1:0] sel_word;

    // Round-robin search starting at ptr and wrapping upward. The loop runs
    // from the farthest candidate to the nearest, so the nearest hit is the
    // last one written and wins. Result is {found, index}.
    function automatic logic [GW:0] rr_pick(input logic [NUM_REQ-1:0] en,
                                            input logic [GW-1:0]      ptr);
        logic [GW:0] pos;
        logic [GW:0] res;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + (GW+1)'(i);
            if (pos >= (GW+1)'(NUM_REQ)) begin
                pos = pos - (GW+1)'(NUM_REQ);
            end
            if (en[pos[GW-1:0]]) begin
                res = {1'b1, pos[GW-1:0]};
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        en_d     = en_q;
        mode_d   = mode_q;
        ack_d    = 1'b0;
        sel_word = '0;

        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q == GW'(k)) begin
                sel_word = req_data_i[k*DATA_BITWIDTH +: DATA_BITWIDTH];
            end
        end

        // The output stage can take a word if it is empty or is draining this cycle.
        out_free    = ~en_q | ready_i;
        req_ready_o = '0;
        if (state_q == BURST && out_free) begin
            req_ready_o[grant_q] = 1'b1;
        end
        xfer    = (state_q == BURST) & req_enable_i[grant_q] & out_free;
        mode_ok = (state_q == IDLE) & ~en_q & mode_we_i;
        pick    = rr_pick(req_enable_i, ptr_q);

        // A fill wins over a drain, so back-to-back words keep enable high.
        if (xfer) begin
            data_d = sel_word;
            en_d   = 1'b1;
        end else if (ready_i) begin
            en_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // An accepted mode write takes this cycle instead of a grant.
                if (mode_ok) begin
                    mode_d = mode_cfg_i;
                    ack_d  = 1'b1;
                end else if (pick[GW]) begin
                    grant_d = pick[GW-1:0];
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    if (cnt_q == 8'(BURST_LEN - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        ptr_d   = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            mode_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            en_q    <= en_d;
            mode_q  <= mode_d;
            ack_q   <= ack_d;
        end
    end

    assign data_o     = data_q;
    assign enable_o   = en_q;
    assign grant_o    = grant_q;
    assign busy_o     = (state_q == BURST);
    assign mode_o     = mode_q;
    assign mode_ack_o = ack_q;

endmodule

// File: doc/af_scheduler.md
Name: af_scheduler

Overview:
- Shares one activation-function cluster between NUM_REQ psum producers, e.g. per-router output groups.
- Arbitrates round-robin in fixed-length bursts and registers the selected word into a one-deep output stage that drives the cluster's data/enable inputs.
- Owns the cluster's mode register and accepts mode changes only when the datapath is drained.

Parameters:
- DATA_BITWIDTH, 40, width of one packed data word (two halves).
- MODES, 2, number of activation modes; sets mode width.
- NUM_REQ, 4, number of requesters; legal range 2..16.
- BURST_LEN, 4, words granted per burst; legal range 1..255.

Ports:
- clk_i, input, 1, clock.
- rst_ni, input, 1, reset; asynchronous, active-low.
- req_data_i, input, NUM_REQ*DATA_BITWIDTH, requester words; requester k occupies slice [k*DATA_BITWIDTH +: DATA_BITWIDTH].
- req_enable_i, input, NUM_REQ, per-requester valid.
- req_ready_o, output, NUM_REQ, per-requester ready.
- data_o, output, DATA_BITWIDTH, registered word to the cluster.
- enable_o, output, 1, data_o valid.
- ready_i, input, 1, cluster/downstream ready.
- grant_o, output, $clog2(NUM_REQ), index of the current or last burst owner.
- busy_o, output, 1, high while in BURST state.
- mode_cfg_i, input, $clog2(MODES), new mode value.
- mode_we_i, input, 1, mode write strobe.
- mode_ack_o, output, 1, one-cycle pulse when a mode write is accepted.
- mode_o, output, $clog2(MODES), mode to the cluster.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer 0; burst counter 0; mode register 0. Reset mid-burst discards the output word and the partial burst immediately.
- States:
  - IDLE: search req_enable_i starting at the pointer, wrapping upward. On a hit with index g, load grant_o = g and clear the counter; enter BURST next cycle (one-cycle arbitration bubble). No hit: stay in IDLE.
  - BURST:
    - req_ready_o[k] = (k == grant_o) & (~enable_o | ready_i). All other ready bits are 0.
    - Input transfer when req_enable_i[g] & req_ready_o[g]. The word is captured into data_o and enable_o is set the next cycle.
    - Each transfer increments the counter. On the transfer that brings the count to BURST_LEN, enter IDLE with pointer = (g+1) mod NUM_REQ.
    - If the owner deasserts enable mid-burst, the grant is held and the scheduler waits. There is no timeout and no preemption.
- Output stage:
  - enable_o is cleared when ready_i & enable_o and no new transfer occurs in the same cycle.
  - Simultaneous drain and fill keeps enable_o = 1 with the new data, giving full throughput of 1 word/cycle.
  - data_o holds its value while enable_o & ~ready_i.
  - Latency: accepted input word to data_o = 1 cycle.
- Pass-through: data is passed unmodified; no width change.
- Mode:
  - A mode_we_i is accepted only when state is IDLE, enable_o = 0, and no grant is being loaded that cycle. On acceptance, mode_o takes mode_cfg_i next cycle and mode_ack_o pulses for 1 cycle.
  - A write arriving when not accepted is ignored (no ack). The issuer must retry.
  - Mode writes take priority over arbitration: an IDLE cycle with an accepted write does not grant.
- Boundaries:
  - BURST_LEN = 1 gives pure word-level round-robin, still with the one-cycle IDLE bubble.
  - Pointer wraps from NUM_REQ-1 to 0.
  - A single active requester regains the grant after its bubble.
  - ready_i held low fills the output stage; ready_o drops for all requesters and nothing is lost.

Test Plan:
- Reset with NUM_REQ=4 and BURST_LEN=4, all four requesters valid → grants 0,1,2,3,0 in order. Each burst moves exactly 4 words; one idle cycle between bursts; data_o matches each requester's sequence with 1-cycle latency.
- Only requester 2 valid with words 0x00001_00002.. → grant_o=2 repeatedly. 4 words per burst, then a 1-cycle bubble, then grant 2 again.
- ready_i=0 for 5 cycles mid-burst → enable_o stays 1 and data_o stays stable; req_ready_o=0; on release all words arrive in order with none dropped or duplicated.
- mode_we_i=1 with mode_cfg_i=1 during BURST → no mode_ack_o and mode_o stays 0. Retry in IDLE with output empty → mode_ack_o pulses and mode_o=1 next cycle.
- Requester 1 drops enable after 2 of 4 words for 3 cycles while requester 3 is valid → grant stays 1; after 2 more words of requester 1, grant moves to 3.
- rst_ni asserted asynchronously mid-burst with enable_o=1 → enable_o, req_ready_o, grant_o, busy_o and mode_o go to 0 immediately; after release arbitration restarts from requester 0.
